mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/mem_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory request controller: state encoding,
// access-size constants and the response-data helper.
package mem_req_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Writes complete with a zero result, reads return the bus data.
  function automatic logic [31:0] resp_data(input logic is_wr, input logic [31:0] bus_data);
    return is_wr ? 32'h0000_0000 : bus_data;
  endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory operation controller bridging a pipeline stage to an
// SRAM-like bus. Optional same-cycle result forwarding: define MEM_REQ_FWD_EN.
module mem_req_ctrl
  import mem_req_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_allowin,
  input  logic        in_wr,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_addr,
  input  logic [3:0]  in_wstrb,
  input  logic [31:0] in_wdata,
  input  logic        cancel,
  output logic        out_valid,
  input  logic        out_allowout,
  output logic [31:0] out_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  state_t      state;
  state_t      state_nxt;
  logic        drop;
  logic        drop_nxt;
  logic [31:0] data_q;
  logic [31:0] data_nxt;
  logic        transfer;
  logic        fwd;

  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;

  assign in_allowin = (state == S_IDLE) & ~cancel;
  assign transfer   = in_valid & in_allowin;

`ifdef MEM_REQ_FWD_EN
  assign fwd = (state == S_WAIT) & data_ok & ~cancel & out_allowout;
`else
  assign fwd = 1'b0;
`endif

  // Next-state, sticky drop flag and result capture.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    data_nxt  = data_q;
    case (state)
      S_IDLE: begin
        if (transfer) begin
          state_nxt = S_REQ;
          drop_nxt  = 1'b0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        // req must stay up until addr_ok even when flushed; remember the flush.
        if (cancel) begin
          drop_nxt = 1'b1;
        end else begin
          drop_nxt = drop;
        end
        if (addr_ok) begin
          state_nxt = (drop | cancel) ? S_DROP : S_WAIT;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (cancel) begin
          state_nxt = data_ok ? S_IDLE : S_DROP;
        end else if (data_ok) begin
          state_nxt = fwd ? S_IDLE : S_DONE;
          data_nxt  = resp_data(lat_wr, rdata);
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_allowout | cancel) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DROP: begin
        if (data_ok) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DROP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  // State, drop flag and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      drop   <= 1'b0;
      data_q <= 32'h0000_0000;
    end else begin
      state  <= state_nxt;
      drop   <= drop_nxt;
      data_q <= data_nxt;
    end
  end

  // Operation fields are held from acceptance so the bus request stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'h0000_0000;
      lat_wstrb <= 4'h0;
      lat_wdata <= 32'h0000_0000;
    end else if (transfer) begin
      lat_wr    <= in_wr;
      lat_size  <= in_size;
      lat_addr  <= in_addr;
      lat_wstrb <= in_wstrb;
      lat_wdata <= in_wdata;
    end else begin
      lat_wr    <= lat_wr;
      lat_size  <= lat_size;
      lat_addr  <= lat_addr;
      lat_wstrb <= lat_wstrb;
      lat_wdata <= lat_wdata;
    end
  end

  assign req   = (state == S_REQ);
  assign wr    = lat_wr;
  assign size  = lat_size;
  assign addr  = lat_addr;
  assign wstrb = lat_wstrb;
  assign wdata = lat_wdata;

  assign out_valid = ((state == S_DONE) & ~cancel) | fwd;
  assign out_rdata = fwd ? resp_data(lat_wr, rdata) : data_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: vector table, directed corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_mem_req_ctrl;
  import mem_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_allowin, in_wr, cancel, out_valid, out_allowout;
  logic [1:0]  in_size, size;
  logic [31:0] in_addr, in_wdata, out_rdata, addr, wdata, rdata;
  logic [3:0]  in_wstrb, wstrb;
  logic        req, wr, addr_ok, data_ok;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_wr(in_wr), .in_size(in_size), .in_addr(in_addr), .in_wstrb(in_wstrb),
    .in_wdata(in_wdata), .cancel(cancel), .out_valid(out_valid),
    .out_allowout(out_allowout), .out_rdata(out_rdata), .req(req), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  typedef struct {
    logic        iv, cn, ao, dk, oa;
    logic [31:0] rd;
    logic        e_ai, e_rq, e_ov;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic iv, input logic cn, input logic ao, input logic dk,
                              input logic oa, input logic [31:0] rd, input logic e_ai,
                              input logic e_rq, input logic e_ov, input logic [31:0] e_rdata);
    vec_t v;
    v.iv = iv; v.cn = cn; v.ao = ao; v.dk = dk; v.oa = oa; v.rd = rd;
    v.e_ai = e_ai; v.e_rq = e_rq; v.e_ov = e_ov; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    in_valid = 1'b0; cancel = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    out_allowout = 1'b0; rdata = 32'h0;
  endtask

  task automatic set_op(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] d);
    in_wr = w; in_size = s; in_addr = a; in_wstrb = st; in_wdata = d;
  endtask

  // Accept one operation in the current cycle, then leave the REQ cycle pending.
  task automatic accept(input string name);
    in_valid = 1'b1;
    smp();
    chk(name, {31'd0, in_allowin}, 32'd1);
    tick();
    clr();
    in_addr = 32'hFFFF_FFFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a, d, rd, exp;
    logic [3:0]  st;
    int          mode, d1, d2, s, gap;
    logic        cancelled;

    // REQ-021 latency, REQ-024 cancel+data_ok in WAIT, stray data_ok, cancel in IDLE.
    vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    vecs[4]  = mk(1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'hDEAD_BEEF);
    vecs[5]  = mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'hDEAD_BEEF);
    vecs[6]  = mk(0, 1, 0, 1, 0, 32'h1111_1111, 0, 0, 0, 32'hDEAD_BEEF);
    vecs[7]  = mk(1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'hDEAD_BEEF);
    vecs[8]  = mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'hDEAD_BEEF);
    vecs[9]  = mk(0, 0, 0, 1, 0, 32'h1234_5678, 0, 0, 0, 32'hDEAD_BEEF);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 32'h1234_5678);
    vecs[11] = mk(0, 0, 0, 0, 1, 32'h0,         0, 0, 1, 32'h1234_5678);
    vecs[12] = mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 32'h1234_5678);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h1234_5678);
    vecs[14] = mk(1, 1, 0, 0, 0, 32'h0,         0, 0, 0, 32'h1234_5678);
    vecs[15] = mk(0, 0, 1, 0, 0, 32'h0,         1, 0, 0, 32'h1234_5678);
    vecs[16] = mk(0, 0, 0, 1, 0, 32'hAAAA_5555, 1, 0, 0, 32'h1234_5678);

    clr();
    set_op(1'b0, SZ_W, 32'h1C00_0000, 4'hF, 32'h0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    smp();
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_rdata", out_rdata, 32'h0);
    chk("reset_allowin", {31'd0, in_allowin}, 32'd1);
    tick();

    for (int i = 0; i < 17; i++) begin
      in_valid = vecs[i].iv; cancel = vecs[i].cn; addr_ok = vecs[i].ao;
      data_ok = vecs[i].dk; out_allowout = vecs[i].oa; rdata = vecs[i].rd;
      smp();
      chk($sformatf("vec%0d_allowin", i), {31'd0, in_allowin}, {31'd0, vecs[i].e_ai});
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, vecs[i].e_rq});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d_out_rdata", i), out_rdata, vecs[i].e_rdata);
      if (vecs[i].e_rq) chk($sformatf("vec%0d_addr", i), addr, 32'h1C00_0000);
      tick();
      clr();
    end

    // addr_ok withheld for 3 cycles: request stays stable.
    set_op(1'b0, SZ_H, 32'h1C00_0040, 4'hF, 32'h0);
    accept("stall_accept");
    for (int i = 0; i < 4; i++) begin
      addr_ok = (i == 3);
      smp();
      chk($sformatf("stall_req%0d", i), {31'd0, req}, 32'd1);
      chk($sformatf("stall_addr%0d", i), addr, 32'h1C00_0040);
      chk($sformatf("stall_size%0d", i), {30'd0, size}, {30'd0, SZ_H});
      tick(); clr();
    end
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    smp(); chk("stall_wait_req", {31'd0, req}, 32'd0);
    tick(); clr();
    out_allowout = 1'b1;
    smp();
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_out_rdata", out_rdata, 32'hCAFE_F00D);
    tick(); clr();
    smp(); chk("stall_allowin_again", {31'd0, in_allowin}, 32'd1);
    tick();

    // Cancel in REQ: req held, no result, IDLE after data_ok.
    set_op(1'b0, SZ_W, 32'h1C00_0100, 4'hF, 32'h0);
    accept("cancel_req_accept");
    cancel = 1'b1;
    smp(); chk("cancel_req_req_held", {31'd0, req}, 32'd1);
    tick(); clr();
    addr_ok = 1'b1;
    smp(); chk("cancel_req_req_still", {31'd0, req}, 32'd1);
    tick(); clr();
    smp(); chk("cancel_req_drop_ov", {31'd0, out_valid}, 32'd0);
    tick();
    data_ok = 1'b1; rdata = 32'h5A5A_5A5A;
    smp(); chk("cancel_req_dataok_ov", {31'd0, out_valid}, 32'd0);
    tick(); clr();
    smp();
    chk("cancel_req_idle", {31'd0, in_allowin}, 32'd1);
    chk("cancel_req_ov_after", {31'd0, out_valid}, 32'd0);
    chk("cancel_req_rdata_kept", out_rdata, 32'hCAFE_F00D);
    tick();

    // Write held for 5 cycles of backpressure, result reads as zero.
    set_op(1'b1, SZ_H, 32'h1C00_0080, 4'b0011, 32'h0000_BEEF);
    accept("wr_accept");
    addr_ok = 1'b1;
    smp();
    chk("wr_bus_wr", {31'd0, wr}, 32'd1);
    chk("wr_bus_wstrb", {28'd0, wstrb}, 32'd3);
    chk("wr_bus_wdata", wdata, 32'h0000_BEEF);
    tick(); clr();
    data_ok = 1'b1; rdata = 32'h1234_5678;
    smp(); tick(); clr();
    for (int i = 0; i < 6; i++) begin
      out_allowout = (i == 5);
      smp();
      chk($sformatf("wr_hold_ov%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("wr_hold_rdata%0d", i), out_rdata, 32'h0);
      tick(); clr();
    end
    smp(); chk("wr_idle", {31'd0, in_allowin}, 32'd1);
    tick();

    // Cancel while the result waits in DONE.
    set_op(1'b0, SZ_B, 32'h1C00_0003, 4'h8, 32'h0);
    accept("done_cancel_accept");
    addr_ok = 1'b1; smp(); tick(); clr();
    data_ok = 1'b1; rdata = 32'h0000_0077; smp(); tick(); clr();
    cancel = 1'b1;
    smp(); chk("done_cancel_ov", {31'd0, out_valid}, 32'd0);
    tick(); clr();
    smp(); chk("done_cancel_idle", {31'd0, in_allowin}, 32'd1);
    tick();

    // Reset while waiting, then a stray data_ok.
    set_op(1'b0, SZ_W, 32'h1C00_0200, 4'hF, 32'h0);
    accept("rst_accept");
    addr_ok = 1'b1; smp(); tick(); clr();
    rst = 1'b1; tick(); rst = 1'b0;
    smp();
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_allowin", {31'd0, in_allowin}, 32'd1);
    chk("rst_mid_rdata", out_rdata, 32'h0);
    tick();
    data_ok = 1'b1; rdata = 32'h9999_9999; smp(); tick(); clr();
    smp();
    chk("stray_ov", {31'd0, out_valid}, 32'd0);
    chk("stray_allowin", {31'd0, in_allowin}, 32'd1);
    chk("stray_rdata", out_rdata, 32'h0);
    tick();

    // Randomized transactions: every accepted op either yields exactly its
    // result (zero for writes) or, if flushed before its response, nothing.
    for (int t = 0; t < 150; t++) begin
      w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2));
      a = $urandom; st = 4'($urandom); d = $urandom; rd = $urandom;
      mode = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3); s = $urandom_range(0, 3); gap = $urandom_range(0, 2);
      repeat (gap) tick();
      set_op(w, sz, a, st, d);
      accept("rnd_accept");
      cancelled = (mode == 1);
      for (int i = 0; i <= d1; i++) begin
        addr_ok = (i == d1); cancel = (mode == 1) && (i == 0);
        data_ok = 1'($urandom_range(0, 1)); rdata = $urandom;
        smp();
        chk("rnd_req", {31'd0, req}, 32'd1);
        chk("rnd_addr", addr, a);
        chk("rnd_ctl", {25'd0, wr, size, wstrb}, {25'd0, w, sz, st});
        chk("rnd_wdata", wdata, d);
        tick(); clr();
      end
      for (int i = 0; i <= d2; i++) begin
        data_ok = (i == d2); rdata = (i == d2) ? rd : $urandom;
        if (mode == 2 && i == 0) begin
          cancel = 1'b1;
          cancelled = 1'b1;
        end
        smp();
        chk("rnd_wait_req", {31'd0, req}, 32'd0);
        chk("rnd_wait_ov", {31'd0, out_valid}, 32'd0);
        tick(); clr();
      end
      exp = w ? 32'h0 : rd;
      if (!cancelled) begin
        for (int i = 0; i <= s; i++) begin
          out_allowout = (i == s);
          smp();
          chk("rnd_out_valid", {31'd0, out_valid}, 32'd1);
          chk("rnd_out_rdata", out_rdata, exp);
          tick(); clr();
        end
      end
      smp();
      chk("rnd_idle_allowin", {31'd0, in_allowin}, 32'd1);
      chk("rnd_idle_ov", {31'd0, out_valid}, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
